// File: rtl/usb_out_txn_ctrl.sv
// usb_out_txn_ctrl: host-side USB OUT sequencer; sends OUT token and DATAx payload,
// waits for the device handshake, retries on NAK/error/timeout and tracks the data toggle.
module usb_out_txn_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  dev_addr,
    input  logic [3:0]  endp,
    input  logic [63:0] data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic        rx_err,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [3:0]  retries_used,
    output logic        data_toggle
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_TOKEN, S_WAIT_TOKEN, S_SEND_DATA, S_WAIT_DATA, S_WAIT_HS, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic [3:0]    endp_q, endp_d;
    logic [63:0]   data_q, data_d;
    logic [3:0]    retries_q, retries_d;
    logic          toggle_q, toggle_d;
    logic          success_q, success_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          hs_ack, hs_stall, retry;

    always_comb begin
        hs_ack    = rx_valid && !rx_err && rx_pid == PID_ACK;
        hs_stall  = rx_valid && !rx_err && rx_pid == PID_STALL;
        // a received packet takes priority over the timeout in the same cycle
        retry     = (rx_valid && !hs_ack && !hs_stall) ||
                    (!rx_valid && timer_q == TW'(TIMEOUT_CYCLES - 1));
        state_d   = state_q;
        addr_d    = addr_q;
        endp_d    = endp_q;
        data_d    = data_q;
        retries_d = retries_q;
        toggle_d  = toggle_q;
        success_d = success_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d    = dev_addr;
                endp_d    = endp;
                data_d    = data;
                retries_d = '0;
                success_d = 1'b0;
                state_d   = S_SEND_TOKEN;
            end
            S_SEND_TOKEN: state_d = tx_ready ? S_WAIT_TOKEN : S_SEND_TOKEN;
            S_WAIT_TOKEN: state_d = tx_done ? S_SEND_DATA : S_WAIT_TOKEN;
            S_SEND_DATA:  state_d = tx_ready ? S_WAIT_DATA : S_SEND_DATA;
            S_WAIT_DATA: if (tx_done) begin
                timer_d = '0;
                state_d = S_WAIT_HS;
            end
            S_WAIT_HS: begin
                timer_d = timer_q + 1'b1;
                if (hs_ack) begin
                    success_d = 1'b1;
                    toggle_d  = !toggle_q;
                    state_d   = S_DONE;
                end else if (hs_stall) begin
                    state_d = S_DONE;
                end else if (retry) begin
                    if (retries_q < 4'(MAX_RETRIES)) begin
                        retries_d = retries_q + 1'b1;
                        state_d   = S_SEND_TOKEN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            endp_q    <= '0;
            data_q    <= '0;
            retries_q <= '0;
            toggle_q  <= 1'b0;
            success_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            endp_q    <= endp_d;
            data_q    <= data_d;
            retries_q <= retries_d;
            toggle_q  <= toggle_d;
            success_q <= success_d;
            timer_q   <= timer_d;
        end
    end

    assign tx_valid     = state_q == S_SEND_TOKEN || state_q == S_SEND_DATA;
    assign tx_pid       = state_q == S_SEND_TOKEN ? PID_OUT : (toggle_q ? PID_DATA1 : PID_DATA0);
    assign tx_addr      = addr_q;
    assign tx_endp      = endp_q;
    assign tx_data      = data_q;
    assign busy         = state_q != S_IDLE;
    assign done         = state_q == S_DONE;
    assign success      = success_q;
    assign retries_used = retries_q;
    assign data_toggle  = toggle_q;
endmodule

// File: tb/tb_usb_out_txn_ctrl.sv
// tb_usb_out_txn_ctrl: acts as encoder/decoder/device around the OUT sequencer and
// checks packets, handshake outcome, retry count and toggle against an outcome model.
module tb_usb_out_txn_ctrl;
    localparam int TO   = 16;
    localparam int MAXR = 2;
    localparam int R_ACK = 0, R_NAK = 1, R_ERR = 2, R_STALL = 3, R_TO = 4, R_OTHER = 5;
    localparam logic [3:0] P_OUT = 4'b0001, P_D0 = 4'b0011, P_D1 = 4'b1011;
    localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;

    logic clk = 1'b0, rst, start, tx_ready, tx_done, rx_valid, rx_err;
    logic [6:0] dev_addr, tx_addr;
    logic [3:0] endp, tx_endp, tx_pid, rx_pid, retries_used;
    logic [63:0] data, tx_data;
    logic tx_valid, busy, done, success, data_toggle;

    int n_cmp = 0, n_err = 0;
    int resp [3];
    bit rnd;
    int rdy_dly, done_dly, hs_dly;
    logic [6:0] cur_a;
    logic [3:0] cur_e;
    logic [63:0] cur_d;
    logic model_tog;

    always #5 clk = ~clk;

    usb_out_txn_ctrl #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .endp(endp), .data(data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_pid(tx_pid), .tx_addr(tx_addr),
        .tx_endp(tx_endp), .tx_data(tx_data), .tx_done(tx_done), .rx_valid(rx_valid),
        .rx_pid(rx_pid), .rx_err(rx_err), .busy(busy), .done(done), .success(success),
        .retries_used(retries_used), .data_toggle(data_toggle)
    );

    // Outcome of one transaction from the device's per-attempt responses.
    function automatic void model(output int att, output bit succ, output int ret);
        att = 0; succ = 0; ret = 0;
        for (int i = 0; i < MAXR + 1; i++) begin
            att = i + 1;
            if (resp[i] == R_ACK) begin succ = 1; return; end
            if (resp[i] == R_STALL) return;
            if (ret == MAXR) return;
            ret++;
        end
    endfunction

    task automatic garbage_inputs;
        dev_addr = 7'($urandom);
        endp     = 4'($urandom);
        data     = {$urandom, $urandom};
    endtask

    task automatic serve_packet(input logic [3:0] pid);
        int t = 0;
        int rd = rnd ? int'($urandom_range(0, 3)) : rdy_dly;
        int dd = rnd ? int'($urandom_range(1, 6)) : done_dly;
        while (!tx_valid && t < 50) begin @(negedge clk); t++; end
        n_cmp++;
        if (!tx_valid) begin n_err++; $display("FAIL tx_valid_wait: got 0 required 1 (pid %b)", pid); end
        for (int i = 0; i <= rd; i++) begin
            tx_ready = (i == rd);
            n_cmp++;
            if ({tx_valid, tx_pid, tx_addr, tx_endp, tx_data} !== {1'b1, pid, cur_a, cur_e, cur_d}) begin
                n_err++;
                $display("FAIL tx_fields: got v=%b pid=%b a=%h e=%h d=%h required v=1 pid=%b a=%h e=%h d=%h",
                         tx_valid, tx_pid, tx_addr, tx_endp, tx_data, pid, cur_a, cur_e, cur_d);
            end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        n_cmp++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_valid_after_accept: got %b required 0", tx_valid); end
        repeat (dd - 1) begin
            tx_ready = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_pid   = P_ACK;
            start    = 1'($urandom);
            garbage_inputs();
            @(negedge clk);
        end
        tx_ready = 1'b0; rx_valid = 1'b0; start = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic handshake(input int r);
        int cnt = 0;
        int k = rnd ? int'($urandom_range(0, TO - 1)) : hs_dly;
        if (r == R_TO) begin
            while (!tx_valid && !done && cnt < 100) begin @(negedge clk); cnt++; end
            n_cmp++;
            if (cnt != TO) begin n_err++; $display("FAIL timeout_len: got %0d cycles required %0d", cnt, TO); end
        end else begin
            repeat (k) begin
                tx_done = 1'($urandom);
                rx_pid  = 4'($urandom);
                @(negedge clk);
            end
            tx_done  = 1'b0;
            rx_valid = 1'b1;
            rx_err   = (r == R_ERR);
            rx_pid   = r == R_NAK ? P_NAK : r == R_STALL ? P_STALL : r == R_OTHER ? P_D0 : P_ACK;
            @(negedge clk);
            rx_valid = 1'b0;
            rx_err   = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic [3:0] e, input logic [63:0] d);
        int att, ret;
        bit succ;
        logic tog;
        model(att, succ, ret);
        tog = model_tog;
        cur_a = a; cur_e = e; cur_d = d;
        start = 1'b1; dev_addr = a; endp = e; data = d;
        @(negedge clk);
        start = 1'b0;
        garbage_inputs();
        n_cmp++;
        if ({busy, retries_used, success} !== {1'b1, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL accept: got busy=%b ret=%0d succ=%b required busy=1 ret=0 succ=0", busy, retries_used, success);
        end
        for (int i = 0; i < att; i++) begin
            serve_packet(P_OUT);
            serve_packet(tog ? P_D1 : P_D0);
            handshake(resp[i]);
        end
        n_cmp++;
        if ({done, success, retries_used, data_toggle} !== {1'b1, succ, 4'(ret), tog ^ succ}) begin
            n_err++;
            $display("FAIL result: got done=%b succ=%b ret=%0d tog=%b required done=1 succ=%b ret=%0d tog=%b",
                     done, success, retries_used, data_toggle, succ, ret, tog ^ succ);
        end
        start = 1'b1;
        garbage_inputs();
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({done, busy, success} !== {1'b0, 1'b0, succ}) begin
            n_err++;
            $display("FAIL after_done: got done=%b busy=%b succ=%b required done=0 busy=0 succ=%b", done, busy, success, succ);
        end
        model_tog = tog ^ succ;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, tx_valid, success, retries_used, data_toggle, tx_addr, tx_endp, tx_data} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b v=%b succ=%b ret=%0d tog=%b a=%h e=%h d=%h required all 0",
                     busy, done, tx_valid, success, retries_used, data_toggle, tx_addr, tx_endp, tx_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done); end
        model_tog = 1'b0;
    endtask

    task automatic set_fixed(input int r0, input int r1, input int r2, input int rdy);
        rnd = 0; rdy_dly = rdy; done_dly = 20; hs_dly = 5;
        resp[0] = r0; resp[1] = r1; resp[2] = r2;
    endtask

    task automatic test_basic_ack;
        set_fixed(R_ACK, R_ACK, R_ACK, 0);
        run_txn(7'h2B, 4'd4, 64'hDEADBEEF_01234567);
    endtask

    task automatic test_toggle;
        set_fixed(R_ACK, R_ACK, R_ACK, 0);
        run_txn(7'h11, 4'd9, 64'h0123_4567_89AB_CDEF);
    endtask

    task automatic test_nak_retry;
        set_fixed(R_NAK, R_NAK, R_ACK, 0);
        run_txn(7'h3C, 4'd2, 64'hCAFEF00D_55AA55AA);
    endtask

    task automatic test_timeout;
        set_fixed(R_TO, R_TO, R_TO, 0);
        run_txn(7'h01, 4'd15, 64'h1);
    endtask

    task automatic test_err_stall_backpressure;
        set_fixed(R_ERR, R_STALL, R_ACK, 10);
        run_txn(7'h7F, 4'd0, 64'hFFFF_0000_FFFF_0000);
    endtask

    task automatic test_reset_abort;
        bit bad = 0;
        rnd = 0; rdy_dly = 1; done_dly = 3;
        cur_a = 7'h55; cur_e = 4'd5; cur_d = 64'h5555_AAAA_5555_AAAA;
        start = 1'b1; dev_addr = cur_a; endp = cur_e; data = cur_d;
        @(negedge clk);
        start = 1'b0;
        serve_packet(P_OUT);
        serve_packet(model_tog ? P_D1 : P_D0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, tx_valid, data_toggle, done, retries_used, tx_addr, tx_endp, tx_data} !== '0) begin
            n_err++;
            $display("FAIL reset_abort: got busy=%b v=%b tog=%b done=%b ret=%0d a=%h required all 0",
                     busy, tx_valid, data_toggle, done, retries_used, tx_addr);
        end
        repeat (20) begin
            if (done || busy) bad = 1;
            @(negedge clk);
        end
        n_cmp++;
        if (bad) begin n_err++; $display("FAIL no_done_after_abort: got done/busy activity required none"); end
        model_tog = 1'b0;
    endtask

    task automatic test_random;
        rnd = 1;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 3; i++) resp[i] = int'($urandom_range(0, 5));
            run_txn(7'($urandom), 4'($urandom), {$urandom, $urandom});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
        rx_valid = 1'b0; rx_err = 1'b0; rx_pid = 4'd0;
        dev_addr = '0; endp = '0; data = '0;
        test_reset();
        test_basic_ack();
        test_toggle();
        test_nak_retry();
        test_timeout();
        test_err_stall_backpressure();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
